// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers the four hex digits shown on a multiplexed,
// active-low 7-segment display bus and publishes them as complete frames.
// Optional build macro: SEG_INPUT_SYNC_EN adds a two-flop input synchronizer
// (two extra cycles of capture latency) ahead of the stability counter.
module seg7_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       AN0,
    input  logic       AN1,
    input  logic       AN2,
    input  logic       AN3,
    input  logic [6:0] LEDin,
    output logic [3:0] DN0,
    output logic [3:0] DN1,
    output logic [3:0] DN2,
    output logic [3:0] DN3,
    output logic       frame_valid,
    output logic       seg_err
);

    localparam int unsigned SAMP_W = 11;
    localparam int unsigned CNT_W  = 8;
    localparam logic [SAMP_W-1:0] SAMP_IDLE = {4'hF, 7'h7F};
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PUBLISH = 1'b1
    } state_t;

    // Exactly one anode low marks a valid digit strobe.
    function automatic logic is_strobe(input logic [3:0] an);
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: is_strobe = 1'b1;
            default:                            is_strobe = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        case (an)
            4'b1101: an_index = 2'd1;
            4'b1011: an_index = 2'd2;
            4'b0111: an_index = 2'd3;
            default: an_index = 2'd0;
        endcase
    endfunction

    // Returns {legal, nibble}; anything outside the 16 glyphs is illegal.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h01: seg_decode = {1'b1, 4'h0};
            7'h4F: seg_decode = {1'b1, 4'h1};
            7'h12: seg_decode = {1'b1, 4'h2};
            7'h06: seg_decode = {1'b1, 4'h3};
            7'h4C: seg_decode = {1'b1, 4'h4};
            7'h24: seg_decode = {1'b1, 4'h5};
            7'h20: seg_decode = {1'b1, 4'h6};
            7'h0F: seg_decode = {1'b1, 4'h7};
            7'h00: seg_decode = {1'b1, 4'h8};
            7'h04: seg_decode = {1'b1, 4'h9};
            7'h08: seg_decode = {1'b1, 4'hA};
            7'h60: seg_decode = {1'b1, 4'hB};
            7'h31: seg_decode = {1'b1, 4'hC};
            7'h42: seg_decode = {1'b1, 4'hD};
            7'h30: seg_decode = {1'b1, 4'hE};
            7'h38: seg_decode = {1'b1, 4'hF};
            default: seg_decode = {1'b0, 4'h0};
        endcase
    endfunction

    logic [SAMP_W-1:0] samp_in;

`ifdef SEG_INPUT_SYNC_EN
    logic [SAMP_W-1:0] sync1;
    logic [SAMP_W-1:0] sync2;

    // Two-flop synchronizer for the asynchronous display bus.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync1 <= SAMP_IDLE;
            sync2 <= SAMP_IDLE;
        end else begin
            sync1 <= {AN3, AN2, AN1, AN0, LEDin};
            sync2 <= sync1;
        end
    end

    assign samp_in = sync2;
`else
    assign samp_in = {AN3, AN2, AN1, AN0, LEDin};
`endif

    logic [SAMP_W-1:0] samp;
    logic [CNT_W-1:0]  cnt;
    logic              cap;

    // Sample register, stability counter and one-shot capture strobe.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            samp <= SAMP_IDLE;
            cnt  <= '0;
            cap  <= 1'b0;
        end else begin
            samp <= samp_in;
            cap  <= is_strobe(samp_in[10:7]) && (samp_in == samp) && (cnt == CNT_PRE);
            if (!is_strobe(samp_in[10:7])) begin
                cnt <= '0;
            end else if (samp_in != samp) begin
                cnt <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // samp still holds the captured value on the cycle cap is high.
    logic [4:0] dec_c;
    logic [1:0] idx_c;
    assign dec_c = seg_decode(samp[6:0]);
    assign idx_c = an_index(samp[10:7]);

    state_t          state, state_nxt;
    logic [3:0]      seen, seen_nxt;
    logic [3:0][3:0] coll, coll_nxt;
    logic [3:0][3:0] dn, dn_nxt;
    logic            fv_nxt;
    logic            err_nxt;

    // Frame FSM state and output registers.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state       <= ST_COLLECT;
            seen        <= '0;
            coll        <= '0;
            dn          <= '0;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            seen        <= seen_nxt;
            coll        <= coll_nxt;
            dn          <= dn_nxt;
            frame_valid <= fv_nxt;
            seg_err     <= err_nxt;
        end
    end

    // Capture handling, frame completion and atomic publish.
    always_comb begin
        state_nxt = state;
        seen_nxt  = seen;
        coll_nxt  = coll;
        dn_nxt    = dn;
        fv_nxt    = 1'b0;
        err_nxt   = 1'b0;

        if (cap) begin
            if (dec_c[4]) begin
                coll_nxt[idx_c] = dec_c[3:0];
                seen_nxt[idx_c] = 1'b1;
            end else begin
                err_nxt = 1'b1;
            end
        end

        case (state)
            ST_COLLECT: begin
                if (seen_nxt == 4'hF) begin
                    dn_nxt    = coll_nxt;
                    seen_nxt  = 4'h0;
                    fv_nxt    = 1'b1;
                    state_nxt = ST_PUBLISH;
                end
            end
            ST_PUBLISH: state_nxt = ST_COLLECT;
            default:    state_nxt = ST_COLLECT;
        endcase
    end

    assign DN0 = dn[0];
    assign DN1 = dn[1];
    assign DN2 = dn[2];
    assign DN3 = dn[3];

endmodule
